// File: rtl/keystream_generator.sv
`timescale 1ns/1ps
// keystream_generator
// Byte-oriented keystream source built around a 32-bit Galois LFSR.
// A request makes the LFSR step ROUNDS times, then emits one byte formed by
// folding the top byte of the state onto the bottom byte. A KEY_BYTES-byte
// key, most significant byte first, reseeds the LFSR.
// Optional feature macro: KEYSTREAM_COUNTER_EN adds a 16-bit wrapping count of
// emitted bytes on port byte_count_out.

package types_pkg;
    typedef enum logic [1:0] {
        H_GROUND  = 2'd0,
        H_LOADING = 2'd1,
        H_READY   = 2'd2,
        H_BUSY    = 2'd3
    } hash_generator_state_t;
endpackage

module keystream_generator #(
    parameter int          KEY_BYTES    = 4,
    parameter int          ROUNDS       = 8,
    parameter logic [31:0] TAPS         = 32'h8020_0003,
    parameter logic [31:0] DEFAULT_SEED = 32'hACE1_2D5B
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic [7:0]                    key_byte_in,
    input  logic                          key_byte_pulse,
    input  logic                          request_byte_pulse,
    output logic [7:0]                    hash_byte,
    output logic                          hash_byte_pulse,
    output types_pkg::hash_generator_state_t hash_generator_state
`ifdef KEYSTREAM_COUNTER_EN
    ,
    output logic [15:0]                   byte_count_out
`endif
);

    // Parameters narrowed to the widths of the counters they are compared with.
    localparam logic [2:0] KEY_BYTES_W = 3'(KEY_BYTES);
    localparam logic [7:0] ROUNDS_W    = 8'(ROUNDS);

    // One Galois step: shift right, fold the taps in when a one falls out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] shifted;
        shifted = s >> 1;
        if (s[0]) begin
            shifted = shifted ^ TAPS;
        end
        return shifted;
    endfunction

    // An all-zero state would lock the LFSR, so a zero key becomes 1.
    function automatic logic [31:0] seed_from_key(input logic [31:0] key);
        return (key == 32'h0) ? 32'h0000_0001 : key;
    endfunction

    types_pkg::hash_generator_state_t state_q, state_d;

    logic [31:0] lfsr_q,       lfsr_d;
    logic [31:0] shadow_q,     shadow_d;
    logic [2:0]  key_cnt_q,    key_cnt_d;
    logic [7:0]  round_cnt_q,  round_cnt_d;
    logic [7:0]  hash_byte_q,  hash_byte_d;
    logic        hash_pulse_q, hash_pulse_d;

    logic [31:0] lfsr_stepped;
    logic [31:0] shadow_shifted;
    logic [31:0] shadow_first;
    logic [2:0]  key_cnt_inc;

    assign lfsr_stepped   = lfsr_step(lfsr_q);
    assign shadow_shifted = {shadow_q[23:0], key_byte_in};
    assign shadow_first   = {24'h0, key_byte_in};
    assign key_cnt_inc    = key_cnt_q + 3'd1;

    // Next-state and datapath decisions; every target holds unless a case moves it.
    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        shadow_d     = shadow_q;
        key_cnt_d    = key_cnt_q;
        round_cnt_d  = round_cnt_q;
        hash_byte_d  = hash_byte_q;
        hash_pulse_d = 1'b0;

        case (state_q)
            types_pkg::H_GROUND,
            types_pkg::H_READY: begin
                // A key byte wins over a simultaneous request, which is dropped.
                if (key_byte_pulse) begin
                    shadow_d  = shadow_first;
                    key_cnt_d = 3'd1;
                    if (KEY_BYTES_W == 3'd1) begin
                        lfsr_d  = seed_from_key(shadow_first);
                        state_d = types_pkg::H_READY;
                    end else begin
                        state_d = types_pkg::H_LOADING;
                    end
                end else if (request_byte_pulse) begin
                    round_cnt_d = ROUNDS_W;
                    state_d     = types_pkg::H_BUSY;
                end
            end

            types_pkg::H_LOADING: begin
                // Requests are ignored until the key is complete.
                if (key_byte_pulse) begin
                    shadow_d  = shadow_shifted;
                    key_cnt_d = key_cnt_inc;
                    if (key_cnt_inc == KEY_BYTES_W) begin
                        lfsr_d  = seed_from_key(shadow_shifted);
                        state_d = types_pkg::H_READY;
                    end
                end
            end

            types_pkg::H_BUSY: begin
                // Step every cycle; the last step produces the output byte.
                lfsr_d      = lfsr_stepped;
                round_cnt_d = round_cnt_q - 8'd1;
                if (round_cnt_q == 8'd1) begin
                    hash_byte_d  = lfsr_stepped[7:0] ^ lfsr_stepped[31:24];
                    hash_pulse_d = 1'b1;
                    state_d      = types_pkg::H_READY;
                end
            end

            default: begin
                state_d = types_pkg::H_GROUND;
            end
        endcase
    end

    // State and datapath registers; reset restores the default seed and discards any partial key.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= types_pkg::H_GROUND;
            lfsr_q       <= DEFAULT_SEED;
            shadow_q     <= 32'h0;
            key_cnt_q    <= 3'd0;
            round_cnt_q  <= 8'd0;
            hash_byte_q  <= 8'h00;
            hash_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            shadow_q     <= shadow_d;
            key_cnt_q    <= key_cnt_d;
            round_cnt_q  <= round_cnt_d;
            hash_byte_q  <= hash_byte_d;
            hash_pulse_q <= hash_pulse_d;
        end
    end

    assign hash_byte            = hash_byte_q;
    assign hash_byte_pulse      = hash_pulse_q;
    assign hash_generator_state = state_q;

`ifdef KEYSTREAM_COUNTER_EN
    logic [15:0] byte_count_q, byte_count_d;

    // Count each emitted byte one cycle after its pulse; wraps naturally at 16 bits.
    always_comb begin
        byte_count_d = byte_count_q;
        if (hash_pulse_q) begin
            byte_count_d = byte_count_q + 16'd1;
        end
    end

    // Byte counter register; only reset clears it, key loads leave it alone.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            byte_count_q <= 16'h0000;
        end else begin
            byte_count_q <= byte_count_d;
        end
    end

    assign byte_count_out = byte_count_q;
`endif

endmodule

// File: tb/tb_keystream_generator.sv
`timescale 1ns/1ps
// Scoreboard bench for keystream_generator: a ROUNDS=1 instance for byte values
// and a ROUNDS=8 instance for request timing. Expected bytes are hand-derived.
module tb_keystream_generator;

    typedef struct {
        logic [7:0] b;
        int         cyc;
    } exp_t;

    logic clk;
    logic nrst;
    int   cyc;
    int   n_checks;
    int   n_pass;

    logic [7:0] k1_byte, k8_byte;
    logic       k1_pulse, k8_pulse, r1_req, r8_req;
    logic [7:0] hb1, hb8;
    logic       hp1, hp8;
    types_pkg::hash_generator_state_t st1, st8;
`ifdef KEYSTREAM_COUNTER_EN
    logic [15:0] bc1, bc8;
`endif

    exp_t q1[$];
    exp_t q8[$];

    keystream_generator #(.KEY_BYTES(4), .ROUNDS(1)) dut_r1 (
        .clk                  (clk),
        .nrst                 (nrst),
        .key_byte_in          (k1_byte),
        .key_byte_pulse       (k1_pulse),
        .request_byte_pulse   (r1_req),
        .hash_byte            (hb1),
        .hash_byte_pulse      (hp1),
        .hash_generator_state (st1)
`ifdef KEYSTREAM_COUNTER_EN
        ,
        .byte_count_out       (bc1)
`endif
    );

    keystream_generator #(.KEY_BYTES(4), .ROUNDS(8)) dut_r8 (
        .clk                  (clk),
        .nrst                 (nrst),
        .key_byte_in          (k8_byte),
        .key_byte_pulse       (k8_pulse),
        .request_byte_pulse   (r8_req),
        .hash_byte            (hb8),
        .hash_byte_pulse      (hp8),
        .hash_generator_state (st8)
`ifdef KEYSTREAM_COUNTER_EN
        ,
        .byte_count_out       (bc8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load1(input logic [31:0] key);
        for (int i = 3; i >= 0; i--) begin
            k1_byte  = key[i*8 +: 8];
            k1_pulse = 1'b1;
            tick(1);
        end
        k1_pulse = 1'b0;
    endtask

    task automatic load8(input logic [31:0] key);
        for (int i = 3; i >= 0; i--) begin
            k8_byte  = key[i*8 +: 8];
            k8_pulse = 1'b1;
            tick(1);
        end
        k8_pulse = 1'b0;
    endtask

    // Issue a request on the ROUNDS=1 instance; pulse expected two cycles later.
    task automatic req1(input logic [7:0] exp_b);
        exp_t e;
        e.b   = exp_b;
        e.cyc = cyc + 2;
        q1.push_back(e);
        r1_req = 1'b1;
        tick(1);
        r1_req = 1'b0;
    endtask

    // Issue a request on the ROUNDS=8 instance; pulse expected nine cycles later.
    task automatic req8(input logic [7:0] exp_b);
        exp_t e;
        e.b   = exp_b;
        e.cyc = cyc + 9;
        q8.push_back(e);
        r8_req = 1'b1;
        tick(1);
        r8_req = 1'b0;
    endtask

    // Monitor: every output pulse must match the head of its scoreboard queue.
    always @(negedge clk) begin
        exp_t e;
        if (hp1) begin
            if (q1.size() == 0) begin
                n_checks++;
                $display("FAIL r1_unexpected_pulse: got byte %h at cycle %0d, required no pulse", hb1, cyc);
            end else begin
                e = q1.pop_front();
                $display("r1 byte %h at cycle %0d (expected %h at cycle %0d)", hb1, cyc, e.b, e.cyc);
                check("r1_byte", 32'(hb1), 32'(e.b));
                check("r1_cycle", cyc, e.cyc);
                check("r1_state_at_pulse", 32'(st1), 32'(types_pkg::H_READY));
            end
        end
        if (hp8) begin
            if (q8.size() == 0) begin
                n_checks++;
                $display("FAIL r8_unexpected_pulse: got byte %h at cycle %0d, required no pulse", hb8, cyc);
            end else begin
                e = q8.pop_front();
                $display("r8 byte %h at cycle %0d (expected %h at cycle %0d)", hb8, cyc, e.b, e.cyc);
                check("r8_byte", 32'(hb8), 32'(e.b));
                check("r8_cycle", cyc, e.cyc);
                check("r8_state_at_pulse", 32'(st8), 32'(types_pkg::H_READY));
            end
        end
    end

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_pass   = 0;
        nrst     = 1'b0;
        k1_byte  = 8'h00;
        k8_byte  = 8'h00;
        k1_pulse = 1'b0;
        k8_pulse = 1'b0;
        r1_req   = 1'b0;
        r8_req   = 1'b0;

        // Reset values
        tick(3);
        check("reset_state_r1", 32'(st1), 32'(types_pkg::H_GROUND));
        check("reset_state_r8", 32'(st8), 32'(types_pkg::H_GROUND));
        check("reset_hash_byte", 32'(hb1), 32'h00);
        check("reset_hash_pulse", 32'(hp1), 32'h0);
        nrst = 1'b1;
        tick(1);

        // Key 1: one step gives 80200003 -> 83, then C0300002 -> C2
        load1(32'h0000_0001);
        check("load_done_ready", 32'(st1), 32'(types_pkg::H_READY));
        req1(8'h83);
        tick(2);
        req1(8'hC2);
        tick(2);

        // Zero key is replaced by 1
        load1(32'h0000_0000);
        req1(8'h83);
        tick(2);

        // Key 2: even state, plain shift to 1 -> 01
        load1(32'h0000_0002);
        req1(8'h01);
        tick(3);
        check("hash_byte_holds", 32'(hb1), 32'h01);

        // A new key load leaves hash_byte untouched
        load1(32'h0000_0001);
        check("hash_byte_after_load", 32'(hb1), 32'h01);

        // Request during loading is ignored
        k1_byte = 8'h00; k1_pulse = 1'b1; tick(1);
        k1_pulse = 1'b0; r1_req = 1'b1; tick(1);
        r1_req = 1'b0;
        check("req_in_loading_state", 32'(st1), 32'(types_pkg::H_LOADING));
        k1_byte = 8'h00; k1_pulse = 1'b1; tick(1);
        k1_byte = 8'h00; tick(1);
        k1_byte = 8'h01; tick(1);
        k1_pulse = 1'b0;
        check("load_after_ignored_req", 32'(st1), 32'(types_pkg::H_READY));
        tick(3);

        // Key byte and request together in READY: key wins, request dropped
        k1_byte = 8'h00; k1_pulse = 1'b1; r1_req = 1'b1; tick(1);
        r1_req = 1'b0;
        check("key_priority_state", 32'(st1), 32'(types_pkg::H_LOADING));
        k1_byte = 8'h00; tick(1);
        k1_byte = 8'h00; tick(1);
        k1_byte = 8'h01; tick(1);
        k1_pulse = 1'b0;
        tick(3);
        req1(8'h83);
        tick(2);

        // ROUNDS=8 timing from key 1: bytes D9 then 75
        load8(32'h0000_0001);
        req8(8'hD9);
        tick(2);
        check("r8_busy", 32'(st8), 32'(types_pkg::H_BUSY));
        r8_req = 1'b1; tick(1);
        r8_req = 1'b0;
        tick(5);
        req8(8'h75);
        tick(10);

        // Reset in the middle of BUSY: no pulse, back to ground and default seed
        r8_req = 1'b1; tick(1);
        r8_req = 1'b0;
        tick(2);
        nrst = 1'b0;
        #1;
        check("midbusy_reset_state", 32'(st8), 32'(types_pkg::H_GROUND));
        check("midbusy_reset_byte", 32'(hb8), 32'h00);
        tick(1);
        nrst = 1'b1;
        tick(12);
        // Default seed ACE12D5B steps to D65096AE -> 78
        req1(8'h78);
        tick(2);

`ifdef KEYSTREAM_COUNTER_EN
        // Counter wrap: D65096AE steps to 6B284B57 -> 3C
        force dut_r1.byte_count_q = 16'hFFFF;
        tick(1);
        release dut_r1.byte_count_q;
        tick(1);
        check("count_preset", 32'(bc1), 32'hFFFF);
        req1(8'h3C);
        tick(1);
        check("count_at_pulse", 32'(bc1), 32'hFFFF);
        tick(1);
        check("count_wrapped", 32'(bc1), 32'h0000);
`endif

        tick(5);
        check("r1_queue_drained", q1.size(), 0);
        check("r8_queue_drained", q8.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
